instr_fetch_decode: RTL and testbench

Fetch/decode front end of the execution engine. It drives the shared address bus to read 32-bit instruction words from instruction memory, one at a time. Each word is split into opcode::dest::src1::src2 and routed to a unit class (matrix ALU, integer ALU). The decoded instruction goes to the issue logic over a valid/ready handshake. Fetching stops on a Stop opcode, an illegal opcode, or program overrun.

---
 rtl/ifd_pkg.sv | 45 ++++
 rtl/ifd_opcode_decode.sv | 33 +++
 rtl/instr_fetch_decode.sv | 217 +++++++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifd_pkg.sv
// Shared definitions for the instruction fetch/decode front end:
// opcode values, execution-unit select codes, FSM states and the
// split instruction word.
package ifd_pkg;

   // Matrix ALU opcodes
   localparam logic [7:0] OP_MMULT    = 8'h00;
   localparam logic [7:0] OP_MADD     = 8'h01;
   localparam logic [7:0] OP_MSUB     = 8'h02;
   localparam logic [7:0] OP_MTRANS   = 8'h03;
   localparam logic [7:0] OP_MSCALE   = 8'h04;
   localparam logic [7:0] OP_MSCALEIMM = 8'h05;

   // Integer ALU opcodes
   localparam logic [7:0] OP_IADD     = 8'h10;
   localparam logic [7:0] OP_ISUB     = 8'h11;
   localparam logic [7:0] OP_IMUL     = 8'h12;
   localparam logic [7:0] OP_IDIV     = 8'h13;

   // End of program
   localparam logic [7:0] OP_STOP     = 8'hFF;

   // Execution unit select codes
   localparam logic [3:0] UNIT_NONE   = 4'h0;
   localparam logic [3:0] UNIT_MATRIX = 4'h2;
   localparam logic [3:0] UNIT_INT    = 4'h3;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      CHECK,
      ISSUE,
      HALT
   } ifd_state_e;

   // Instruction word layout: opcode::dest::src1::src2
   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] dest;
      logic [7:0] src1;
      logic [7:0] src2;
   } ifd_instr_t;

endpackage

// File: rtl/ifd_opcode_decode.sv
// Combinational opcode classifier: execution unit, legality and Stop.
module ifd_opcode_decode
   import ifd_pkg::*;
(
   input  logic [7:0] opcode_i,
   output logic [3:0] unit_sel_o,
   output logic       legal_o,
   output logic       is_stop_o
);

   // Map each opcode to its unit; anything not listed is illegal
   always_comb begin
      unit_sel_o = UNIT_NONE;
      legal_o    = 1'b0;
      is_stop_o  = 1'b0;
      case (opcode_i)
         OP_MMULT, OP_MADD, OP_MSUB, OP_MTRANS, OP_MSCALE, OP_MSCALEIMM: begin
            unit_sel_o = UNIT_MATRIX;
            legal_o    = 1'b1;
         end
         OP_IADD, OP_ISUB, OP_IMUL, OP_IDIV: begin
            unit_sel_o = UNIT_INT;
            legal_o    = 1'b1;
         end
         OP_STOP: begin
            legal_o    = 1'b1;
            is_stop_o  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end. Reads one 32-bit word at a time from
// instruction memory, splits it into fields, classifies the opcode and
// hands it to the issue logic over a valid/ready handshake. Halts on Stop,
// on an illegal opcode, or when the last program word has been issued.
// Optional build macro IFD_PERF_CNT_EN adds IssueCount/StallCount outputs.
module instr_fetch_decode
   import ifd_pkg::*;
#(
   parameter logic [3:0]  INSTR_SEL   = 4'h8,
   parameter int unsigned INSTR_DEPTH = 10,
   parameter int unsigned PC_W        = 12
) (
   input  logic            Clk,
   input  logic            nReset,
   input  logic            Start,
   output logic [15:0]     Address,
   output logic            nRead,
   input  logic [255:0]    InstrData,
   output logic            InstrValid,
   input  logic            InstrReady,
   output logic [7:0]      Opcode,
   output logic [7:0]      Dest,
   output logic [7:0]      Src1,
   output logic [7:0]      Src2,
   output logic [3:0]      UnitSel,
   output logic [PC_W-1:0] Pc,
   output logic            Halted,
   output logic            Illegal,
   output logic            Overrun
`ifdef IFD_PERF_CNT_EN
   ,
   output logic [15:0]     IssueCount,
   output logic [15:0]     StallCount
`endif
);

   ifd_state_e      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   ifd_instr_t      instr_q, instr_d;
   logic [3:0]      unit_q, unit_d;
   logic            legal_q, legal_d;
   logic            stop_q, stop_d;
   logic            halted_q, halted_d;
   logic            illegal_q, illegal_d;
   logic            overrun_q, overrun_d;
   logic [15:0]     addr_q, addr_d;
   logic            nread_q, nread_d;

   logic [3:0]      dec_unit;
   logic            dec_legal;
   logic            dec_stop;
   logic            start_ok;
   logic            accept;
   logic            last_pc;
   logic            unused_data;

   // Only the low word of the wide memory bus carries the instruction
   assign unused_data = ^InstrData[255:32];

   // Start is honoured only when the engine is not mid-instruction
   assign start_ok = Start && ((state_q == IDLE) || (state_q == HALT));
   assign accept   = (state_q == ISSUE) && InstrReady;
   assign last_pc  = (pc_q == PC_W'(INSTR_DEPTH - 1));

   // Classify straight off the memory bus so the class is registered
   // together with the fields in CAPTURE
   ifd_opcode_decode u_decode (
      .opcode_i   (InstrData[31:24]),
      .unit_sel_o (dec_unit),
      .legal_o    (dec_legal),
      .is_stop_o  (dec_stop)
   );

   // FSM state register
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, HALT: if (Start) state_d = FETCH;
         FETCH:      state_d = CAPTURE;
         CAPTURE:    state_d = CHECK;
         CHECK:      state_d = (stop_q || !legal_q) ? HALT : ISSUE;
         ISSUE:      if (InstrReady) state_d = last_pc ? HALT : FETCH;
         default:    state_d = IDLE;
      endcase
   end

   // Next values for PC, captured fields, sticky flags and the memory bus
   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      unit_d    = unit_q;
      legal_d   = legal_q;
      stop_d    = stop_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      overrun_d = overrun_q;
      if (start_ok) begin
         pc_d      = '0;
         halted_d  = 1'b0;
         illegal_d = 1'b0;
         overrun_d = 1'b0;
      end
      case (state_q)
         CAPTURE: begin
            instr_d = InstrData[31:0];
            unit_d  = dec_unit;
            legal_d = dec_legal;
            stop_d  = dec_stop;
         end
         CHECK: begin
            if (!legal_q) begin
               illegal_d = 1'b1;
               halted_d  = 1'b1;
            end else if (stop_q) begin
               halted_d  = 1'b1;
            end
         end
         ISSUE: begin
            if (InstrReady) begin
               if (last_pc) begin
                  overrun_d = 1'b1;
                  halted_d  = 1'b1;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
      // The bus registers follow the state being entered, so the read
      // strobe and address are glitch-free for exactly the FETCH cycle
      addr_d  = (state_d == FETCH) ? {INSTR_SEL, pc_d} : 16'h0000;
      nread_d = (state_d != FETCH);
   end

   // Datapath and flag registers; reset also abandons any pending read
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         pc_q      <= '0;
         instr_q   <= '0;
         unit_q    <= UNIT_NONE;
         legal_q   <= 1'b0;
         stop_q    <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         overrun_q <= 1'b0;
         addr_q    <= 16'h0000;
         nread_q   <= 1'b1;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         unit_q    <= unit_d;
         legal_q   <= legal_d;
         stop_q    <= stop_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         overrun_q <= overrun_d;
         addr_q    <= addr_d;
         nread_q   <= nread_d;
      end
   end

   // FSM outputs and registered fields onto the ports
   always_comb begin
      InstrValid = (state_q == ISSUE);
      Address    = addr_q;
      nRead      = nread_q;
      Opcode     = instr_q.opcode;
      Dest       = instr_q.dest;
      Src1       = instr_q.src1;
      Src2       = instr_q.src2;
      UnitSel    = unit_q;
      Pc         = pc_q;
      Halted     = halted_q;
      Illegal    = illegal_q;
      Overrun    = overrun_q;
   end

`ifdef IFD_PERF_CNT_EN
   logic [15:0] issue_cnt_q, issue_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating counts of accepted instructions and back-pressured cycles
   always_comb begin
      issue_cnt_d = issue_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (start_ok) begin
         issue_cnt_d = 16'h0000;
         stall_cnt_d = 16'h0000;
      end else if (state_q == ISSUE) begin
         if (InstrReady && (issue_cnt_q != 16'hFFFF)) issue_cnt_d = issue_cnt_q + 16'h0001;
         if (!InstrReady && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'h0001;
      end
   end

   // Performance counter registers
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         issue_cnt_q <= 16'h0000;
         stall_cnt_q <= 16'h0000;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign IssueCount = issue_cnt_q;
   assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: a program-level reference model predicts
// the fetch addresses, issued words, final flags and PC of each program;
// a per-cycle compare process checks the DUT against it, and directed
// scenarios pin latency, back-pressure, illegal/overrun halts and reset.
module tb_instr_fetch_decode;

   localparam int DEPTH = 10;

   logic         Clk = 1'b0;
   logic         nReset;
   logic         Start;
   logic [15:0]  Address;
   logic         nRead;
   logic [255:0] InstrData;
   logic         InstrValid;
   logic         InstrReady;
   logic [7:0]   Opcode, Dest, Src1, Src2;
   logic [3:0]   UnitSel;
   logic [11:0]  Pc;
   logic         Halted, Illegal, Overrun;
`ifdef IFD_PERF_CNT_EN
   logic [15:0]  IssueCount, StallCount;
`endif

   logic [31:0]  mem [0:15];

   int n_total;
   int n_pass;

   // Reference model state
   logic [31:0] exp_q[$];
   int  exp_fetches, exp_issues, exp_pc;
   bit  exp_ill, exp_ovr;
   int  fetch_idx, issue_idx, m_issue, m_stall, n_valid;
   bit  chk_en;
   int  ready_mode;   // 0: Ready high, 1: random, 2: driven by scenario

   instr_fetch_decode dut (
      .Clk        (Clk),
      .nReset     (nReset),
      .Start      (Start),
      .Address    (Address),
      .nRead      (nRead),
      .InstrData  (InstrData),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .Opcode     (Opcode),
      .Dest       (Dest),
      .Src1       (Src1),
      .Src2       (Src2),
      .UnitSel    (UnitSel),
      .Pc         (Pc),
      .Halted     (Halted),
      .Illegal    (Illegal),
      .Overrun    (Overrun)
`ifdef IFD_PERF_CNT_EN
      ,
      .IssueCount (IssueCount),
      .StallCount (StallCount)
`endif
   );

   always #5 Clk = ~Clk;

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Synchronous instruction memory: data for a read strobed in one cycle
   // appears in the next; otherwise the bus carries junk
   always @(posedge Clk) begin
      logic [255:0] v;
      v = rnd256();
      if (!nRead) v[31:0] = (Address[11:0] < 12'd16) ? mem[Address[3:0]] : 32'hDEAD_BEEF;
      InstrData <= v;
   end

   function automatic bit is_legal(input logic [7:0] op);
      return (op <= 8'h05) || (op >= 8'h10 && op <= 8'h13) || (op == 8'hFF);
   endfunction

   function automatic logic [3:0] unit_of(input logic [7:0] op);
      if (op <= 8'h05) return 4'h2;
      if (op >= 8'h10 && op <= 8'h13) return 4'h3;
      return 4'h0;
   endfunction

   function automatic logic [7:0] rand_legal();
      int idx;
      idx = $urandom_range(0, 9);
      return (idx < 6) ? 8'(idx) : 8'(16 + idx - 6);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Predict the whole run of the program currently in mem
   task automatic build_model();
      bit done;
      logic [7:0] op;
      exp_q.delete();
      exp_fetches = 0;
      exp_ill = 0;
      exp_ovr = 0;
      exp_pc = 0;
      done = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!done) begin
            op = mem[i][31:24];
            exp_fetches++;
            exp_pc = i;
            if (op == 8'hFF) begin
               done = 1;
            end else if (!is_legal(op)) begin
               exp_ill = 1;
               done = 1;
            end else begin
               exp_q.push_back(mem[i]);
               if (i == DEPTH - 1) exp_ovr = 1;
            end
         end
      end
      exp_issues = exp_q.size();
   endtask

   // Per-cycle comparison against the model; also drives random Ready
   task automatic compare_loop();
      logic [31:0] w;
      forever begin
         @(posedge Clk);
         #1;
         if (ready_mode == 1) InstrReady = ($urandom_range(0, 3) != 0);
         @(negedge Clk);
         if (chk_en && nReset) begin
            if (!nRead) begin
               chk("fetch_addr", Address, {4'h8, 12'(fetch_idx)});
               if (fetch_idx >= exp_fetches) chk("extra_fetch", fetch_idx, exp_fetches - 1);
               fetch_idx++;
            end
            if (InstrValid) begin
               n_valid++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_valid", InstrValid, 1'b0);
               end else begin
                  w = exp_q[0];
                  chk("opcode", Opcode, w[31:24]);
                  chk("dest", Dest, w[23:16]);
                  chk("src1", Src1, w[15:8]);
                  chk("src2", Src2, w[7:0]);
                  chk("unitsel", UnitSel, unit_of(w[31:24]));
                  chk("pc_issue", Pc, issue_idx);
                  chk("nread_in_issue", nRead, 1'b1);
                  if (InstrReady) begin
                     void'(exp_q.pop_front());
                     issue_idx++;
                     m_issue++;
                  end else begin
                     m_stall++;
                  end
               end
            end
         end
      end
   endtask

   // Model a program and pulse Start; returns one cycle after Start is sampled
   task automatic start_prog(input int rmode);
      build_model();
      fetch_idx = 0;
      issue_idx = 0;
      m_issue = 0;
      m_stall = 0;
      n_valid = 0;
      ready_mode = rmode;
      if (rmode == 0) InstrReady = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b1;
      chk_en = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
   endtask

   // Wait (bounded) for the halt and check the end state against the model
   task automatic finish_prog();
      int k;
      logic [31:0] last;
      k = 0;
      while (!Halted && k < 3000) begin
         @(posedge Clk);
         #1;
         k++;
      end
      chk("halt_reached", Halted, 1'b1);
      @(posedge Clk);
      #1;
      last = mem[exp_pc];
      chk("illegal_flag", Illegal, exp_ill);
      chk("overrun_flag", Overrun, exp_ovr);
      chk("final_pc", Pc, exp_pc);
      chk("halt_valid", InstrValid, 1'b0);
      chk("halt_nread", nRead, 1'b1);
      chk("halt_addr", Address, 16'h0000);
      chk("pending_issues", exp_q.size(), 0);
      chk("fetch_count", fetch_idx, exp_fetches);
      chk("issue_count", m_issue, exp_issues);
      chk("held_opcode", Opcode, last[31:24]);
      chk("held_fields", {Dest, Src1, Src2}, last[23:0]);
      chk("held_unitsel", UnitSel, unit_of(last[31:24]));
`ifdef IFD_PERF_CNT_EN
      chk("perf_issue", IssueCount, m_issue);
      chk("perf_stall", StallCount, m_stall);
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_nread"}, nRead, 1'b1);
      chk({tag, "_addr"}, Address, 16'h0000);
      chk({tag, "_valid"}, InstrValid, 1'b0);
      chk({tag, "_fields"}, {Opcode, Dest, Src1, Src2}, 32'h0);
      chk({tag, "_unitsel"}, UnitSel, 4'h0);
      chk({tag, "_pc"}, Pc, 12'h000);
      chk({tag, "_flags"}, {Halted, Illegal, Overrun}, 3'b000);
`ifdef IFD_PERF_CNT_EN
      chk({tag, "_perf"}, {IssueCount, StallCount}, 32'h0);
`endif
   endtask

   // Assert reset mid-program after the given number of extra cycles
   task automatic reset_mid(input int extra, input string tag);
      for (int i = 0; i < DEPTH; i++) mem[i] = {rand_legal(), 24'($urandom)};
      mem[2] = 32'hFF000000;
      start_prog(0);
      repeat (extra) begin
         @(posedge Clk);
         #1;
      end
      #1;
      chk_en = 1'b0;
      nReset = 1'b0;
      #1;
      check_reset_outputs(tag);
      @(posedge Clk);
      #1;
      nReset = 1'b1;
      start_prog(0);
      chk({tag, "_refetch_nread"}, nRead, 1'b0);
      chk({tag, "_refetch_addr"}, Address, 16'h8000);
      finish_prog();
   endtask

   initial begin
      int k;
      int r;
      logic [7:0] op;
      n_total = 0;
      n_pass = 0;
      chk_en = 1'b0;
      ready_mode = 0;
      nReset = 1'b0;
      Start = 1'b0;
      InstrReady = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      fork
         compare_loop();
      join_none

      repeat (3) @(posedge Clk);
      #1;
      check_reset_outputs("reset");
      nReset = 1'b1;

      // Two matrix ops then Stop, Ready high
      mem[0] = 32'h01020001;
      mem[1] = 32'h02030001;
      mem[2] = 32'hFF030300;
      start_prog(0);
      chk("first_fetch_nread", nRead, 1'b0);
      chk("first_fetch_addr", Address, 16'h8000);
      k = 1;
      while (!InstrValid && k < 20) begin
         @(posedge Clk);
         #1;
         k++;
      end
      chk("first_valid_latency", k, 4);
      chk("first_opcode", Opcode, 8'h01);
      chk("first_unitsel", UnitSel, 4'h2);
      finish_prog();
      chk("plan_issues", m_issue, 2);
      chk("plan_halted", Halted, 1'b1);

      // Back-pressure for five cycles, with a Start pulse that must be ignored
      mem[0] = 32'h120A0001;
      mem[1] = 32'hFF000000;
      InstrReady = 1'b0;
      start_prog(2);
      k = 0;
      while (!InstrValid && k < 20) begin
         @(posedge Clk);
         #1;
         k++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", InstrValid, 1'b1);
         chk("stall_word", {Opcode, Dest, Src1, Src2}, 32'h120A0001);
         chk("stall_unitsel", UnitSel, 4'h3);
         chk("stall_nread", nRead, 1'b1);
         chk("stall_pc", Pc, 12'h000);
         if (i == 1) Start = 1'b1;
         if (i == 2) Start = 1'b0;
         @(posedge Clk);
         #1;
      end
      InstrReady = 1'b1;
      finish_prog();
      chk("stall_cycles", m_stall, 5);
`ifdef IFD_PERF_CNT_EN
      chk("stall_count_5", StallCount, 16'd5);
`endif

      // Illegal opcode
      mem[0] = 32'h07000000;
      start_prog(0);
      finish_prog();
      chk("illegal_set", Illegal, 1'b1);
      chk("illegal_halted", Halted, 1'b1);
      chk("illegal_no_valid", n_valid, 0);

      // Start from HALT clears the flags and refetches PC 0
      mem[0] = 32'h10010203;
      mem[1] = 32'hFF000000;
      start_prog(0);
      chk("restart_halted", Halted, 1'b0);
      chk("restart_illegal", Illegal, 1'b0);
      chk("restart_nread", nRead, 1'b0);
      chk("restart_addr", Address, 16'h8000);
      finish_prog();

      // Ten legal words without Stop
      for (int i = 0; i < DEPTH; i++) mem[i] = {rand_legal(), 24'($urandom)};
      start_prog(1);
      finish_prog();
      chk("overrun_set", Overrun, 1'b1);
      chk("overrun_halted", Halted, 1'b1);
      chk("overrun_pc", Pc, 12'd9);
      chk("overrun_issues", m_issue, 10);

      // Reset while fetching and while capturing
      reset_mid(0, "rst_fetch");
      reset_mid(1, "rst_capture");

      // Random programs with random back-pressure
      for (int run = 0; run < 25; run++) begin
         for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) op = 8'hFF;
            else if (r < 12) op = 8'($urandom_range(20, 254));
            else op = rand_legal();
            mem[i] = {op, 24'($urandom)};
         end
         start_prog((run % 4 == 0) ? 0 : 1);
         finish_prog();
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
